// File: rtl/decode_hazard_scoreboard.sv
// Decode-stage register scoreboard: tracks destinations with writes in flight and
// raises hazard_stall for RAW/WAW conflicts or when the outstanding-write budget is used up.
module decode_hazard_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_REGS       = 32,
  parameter int MAX_INFLIGHT   = 4,
  parameter int CNT_W          = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dec_valid,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic                      rs1_valid,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic                      rs2_valid,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic                      rd_valid,
  input  logic                      system_stall,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      flush,
  output logic                      hazard_stall,
  output logic                      issue,
  output logic [NUM_REGS-1:0]       pending,
  output logic [CNT_W-1:0]          inflight_cnt,
  output logic [15:0]               stall_cycles,
  output logic                      wb_err
);

  // Handshake: decode offers an instruction with dec_valid; it is taken in the same
  // cycle exactly when issue=1, otherwise decode holds all fields stable.

  logic [NUM_REGS-1:0] wb_clr;
  logic [NUM_REGS-1:0] rd_oh;
  logic [NUM_REGS-1:0] eff;
  logic [NUM_REGS-1:0] pending_nxt;
  logic [CNT_W-1:0]    cnt_after_wb;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                rd_live;
  logic                src_haz;
  logic                waw_haz;
  logic                full;
  logic                set;
  logic                clr;
  logic                wb_bad;

  always_comb begin
    wb_clr = '0;
    if (wb_valid && wb_rd != '0) wb_clr[wb_rd] = 1'b1;
    rd_oh = '0;
    rd_oh[rd] = 1'b1;
  end

  assign eff     = pending & ~wb_clr;
  assign rd_live = rd_valid && (rd != '0);
  assign src_haz = (rs1_valid && rs1 != '0 && eff[rs1]) ||
                   (rs2_valid && rs2 != '0 && eff[rs2]);
  assign waw_haz = rd_live && eff[rd];

  // Only a writeback that really retires a pending register frees a slot; a stray
  // writeback must not let the count exceed MAX_INFLIGHT.
  assign clr          = |(wb_clr & pending);
  assign cnt_after_wb = inflight_cnt - CNT_W'(clr);
  assign full         = rd_live && (cnt_after_wb == CNT_W'(MAX_INFLIGHT));

  assign hazard_stall = dec_valid && !flush && (src_haz || waw_haz || full);
  assign issue        = dec_valid && !flush && !system_stall && !hazard_stall;

  assign set         = issue && rd_live;
  assign pending_nxt = eff | (set ? rd_oh : '0);
  assign cnt_nxt     = inflight_cnt + CNT_W'(set) - CNT_W'(clr);
  assign wb_bad      = !flush && wb_valid && wb_rd != '0 && !pending[wb_rd];

  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= '0;
      inflight_cnt <= '0;
      stall_cycles <= '0;
      wb_err       <= 1'b0;
    end else begin
      if (flush) begin
        pending      <= '0;
        inflight_cnt <= '0;
      end else begin
        pending      <= pending_nxt;
        inflight_cnt <= cnt_nxt;
      end
      if (hazard_stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      if (wb_bad) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// Bench for decode_hazard_scoreboard: directed vector table, a reset-mid-operation
// sequence, then random traffic against a register-set reference model.
module tb_decode_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid, rs1_valid, rs2_valid, rd_valid;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic        system_stall, wb_valid, flush;
  logic        hazard_stall, issue, wb_err;
  logic [31:0] pending;
  logic [2:0]  inflight_cnt;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  bit          busy [32];
  bit          m_wb_err;
  logic [15:0] m_stall;

  typedef struct {
    logic        dv;
    logic [4:0]  rs1;
    logic        rs1v;
    logic [4:0]  rs2;
    logic        rs2v;
    logic [4:0]  rd;
    logic        rdv;
    logic        sys;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        fl;
    logic        exp_stall;
    logic        exp_issue;
    logic [31:0] exp_pend;
    logic [2:0]  exp_cnt;
  } vec_t;

  decode_hazard_scoreboard dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .rs1(rs1), .rs1_valid(rs1_valid), .rs2(rs2), .rs2_valid(rs2_valid),
    .rd(rd), .rd_valid(rd_valid), .system_stall(system_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .hazard_stall(hazard_stall), .issue(issue), .pending(pending),
    .inflight_cnt(inflight_cnt), .stall_cycles(stall_cycles), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic dv, logic [4:0] r1, logic r1v, logic [4:0] r2, logic r2v,
                              logic [4:0] d, logic dvld, logic sys, logic wbv, logic [4:0] wbrd,
                              logic fl, logic st, logic iss, logic [31:0] pend, logic [2:0] cnt);
    vec_t v;
    v.dv = dv; v.rs1 = r1; v.rs1v = r1v; v.rs2 = r2; v.rs2v = r2v;
    v.rd = d; v.rdv = dvld; v.sys = sys; v.wbv = wbv; v.wbrd = wbrd; v.fl = fl;
    v.exp_stall = st; v.exp_issue = iss; v.exp_pend = pend; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one decode cycle, check the combinational answer, clock, check registered state.
  task automatic apply(input vec_t v);
    bit stray_wb;
    dec_valid = v.dv; rs1 = v.rs1; rs1_valid = v.rs1v; rs2 = v.rs2; rs2_valid = v.rs2v;
    rd = v.rd; rd_valid = v.rdv; system_stall = v.sys; wb_valid = v.wbv; wb_rd = v.wbrd;
    flush = v.fl;
    #1;
    check("hazard_stall", {31'd0, hazard_stall}, {31'd0, v.exp_stall});
    check("issue", {31'd0, issue}, {31'd0, v.exp_issue});
    stray_wb = !v.fl && v.wbv && v.wbrd != 0 && !busy[v.wbrd];
    @(posedge clk);
    @(negedge clk);
    if (stray_wb) m_wb_err = 1'b1;
    if (v.exp_stall && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    for (int i = 0; i < 32; i++) busy[i] = v.exp_pend[i];
    check("pending", pending, v.exp_pend);
    check("inflight_cnt", {29'd0, inflight_cnt}, {29'd0, v.exp_cnt});
    check("stall_cycles", {16'd0, stall_cycles}, {16'd0, m_stall});
    check("wb_err", {31'd0, wb_err}, {31'd0, m_wb_err});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dec_valid = 1'b1; rs1 = 5'($urandom_range(0, 31)); rs1_valid = 1'b1;
    rs2 = 5'd0; rs2_valid = 1'b0; rd = 5'($urandom_range(1, 31)); rd_valid = 1'b1;
    system_stall = 1'b0; wb_valid = 1'b1; wb_rd = 5'($urandom_range(1, 31)); flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) busy[i] = 1'b0;
    m_wb_err = 1'b0;
    m_stall  = 16'd0;
    check("reset pending", pending, 32'd0);
    check("reset inflight_cnt", {29'd0, inflight_cnt}, 32'd0);
    check("reset stall_cycles", {16'd0, stall_cycles}, 32'd0);
    check("reset wb_err", {31'd0, wb_err}, 32'd0);
  endtask

  // Reference: the scoreboard viewed as a set of busy registers.
  task automatic model(inout vec_t v);
    bit after_wb [32];
    int live;
    bit src, waw, full;
    logic [31:0] nxt;
    live = 0;
    for (int i = 0; i < 32; i++) begin
      after_wb[i] = busy[i] && !(v.wbv && v.wbrd != 0 && int'(v.wbrd) == i);
      if (after_wb[i]) live++;
    end
    src  = (v.rs1v && v.rs1 != 0 && after_wb[v.rs1]) || (v.rs2v && v.rs2 != 0 && after_wb[v.rs2]);
    waw  = v.rdv && v.rd != 0 && after_wb[v.rd];
    full = v.rdv && v.rd != 0 && live == 4;
    v.exp_stall = v.dv && !v.fl && (src || waw || full);
    v.exp_issue = v.dv && !v.fl && !v.sys && !v.exp_stall;
    nxt = 32'd0;
    if (!v.fl) begin
      for (int i = 0; i < 32; i++) nxt[i] = after_wb[i];
      if (v.exp_issue && v.rdv && v.rd != 0) nxt[v.rd] = 1'b1;
    end
    v.exp_pend = nxt;
    v.exp_cnt  = 3'($countones(nxt));
  endtask

  vec_t tbl [18];

  initial begin
    vec_t v;
    reset = 1'b1;
    dec_valid = 0; rs1 = 0; rs1_valid = 0; rs2 = 0; rs2_valid = 0; rd = 0; rd_valid = 0;
    system_stall = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    for (int i = 0; i < 32; i++) busy[i] = 1'b0;
    m_wb_err = 1'b0;
    m_stall  = 16'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("init pending", pending, 32'd0);
    check("init inflight_cnt", {29'd0, inflight_cnt}, 32'd0);
    check("init stall_cycles", {16'd0, stall_cycles}, 32'd0);
    check("init wb_err", {31'd0, wb_err}, 32'd0);

    //            dv rs1 v rs2 v rd v sys wbv wbrd fl  stall iss pend       cnt
    tbl[0]  = mk(1, 0,  0, 0, 0, 5, 1, 0, 0, 0,  0,  0, 1, 32'h20,    3'd1);
    tbl[1]  = mk(1, 5,  1, 0, 0, 0, 0, 0, 0, 0,  0,  1, 0, 32'h20,    3'd1);
    tbl[2]  = mk(1, 5,  1, 0, 0, 0, 0, 0, 1, 5,  0,  0, 1, 32'h0,     3'd0);
    tbl[3]  = mk(1, 0,  0, 0, 0, 7, 1, 0, 0, 0,  0,  0, 1, 32'h80,    3'd1);
    tbl[4]  = mk(1, 0,  0, 0, 0, 7, 1, 0, 0, 0,  0,  1, 0, 32'h80,    3'd1);
    tbl[5]  = mk(1, 0,  0, 0, 0, 7, 1, 0, 1, 7,  0,  0, 1, 32'h80,    3'd1);
    tbl[6]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 1, 7,  0,  0, 0, 32'h0,     3'd0);
    tbl[7]  = mk(1, 0,  0, 0, 0, 1, 1, 0, 0, 0,  0,  0, 1, 32'h2,     3'd1);
    tbl[8]  = mk(1, 0,  0, 0, 0, 2, 1, 0, 0, 0,  0,  0, 1, 32'h6,     3'd2);
    tbl[9]  = mk(1, 0,  0, 0, 0, 3, 1, 0, 0, 0,  0,  0, 1, 32'hE,     3'd3);
    tbl[10] = mk(1, 0,  0, 0, 0, 4, 1, 0, 0, 0,  0,  0, 1, 32'h1E,    3'd4);
    tbl[11] = mk(1, 0,  0, 0, 0, 8, 1, 0, 0, 0,  0,  1, 0, 32'h1E,    3'd4);
    tbl[12] = mk(1, 0,  0, 0, 0, 8, 1, 0, 1, 2,  0,  0, 1, 32'h11A,   3'd4);
    tbl[13] = mk(1, 0,  0, 3, 1, 0, 0, 0, 0, 0,  0,  1, 0, 32'h11A,   3'd4);
    tbl[14] = mk(1, 10, 1, 0, 0, 0, 0, 1, 0, 0,  0,  0, 0, 32'h11A,   3'd4);
    tbl[15] = mk(1, 0,  1, 0, 0, 0, 1, 0, 0, 0,  0,  0, 1, 32'h11A,   3'd4);
    tbl[16] = mk(0, 0,  0, 0, 0, 0, 0, 0, 1, 0,  0,  0, 0, 32'h11A,   3'd4);
    tbl[17] = mk(1, 0,  0, 0, 0, 9, 1, 0, 1, 3,  1,  0, 0, 32'h0,     3'd0);
    for (int i = 0; i < 18; i++) apply(tbl[i]);

    // Reset in the middle of activity: two writes pending, stray writeback, stalls counted.
    apply(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 32'h20, 3'd1));
    apply(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 1, 32'h60, 3'd2));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 32'h60, 3'd2));
    for (int i = 0; i < 4; i++) apply(mk(1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h60, 3'd2));
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 32'h0, 3'd0));

    // Random traffic on a narrow register window so hazards and full are frequent.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        continue;
      end
      v.dv   = ($urandom_range(0, 9) < 8);
      v.rs1  = 5'($urandom_range(0, 7)); v.rs1v = 1'($urandom_range(0, 1));
      v.rs2  = 5'($urandom_range(0, 7)); v.rs2v = 1'($urandom_range(0, 1));
      v.rd   = 5'($urandom_range(0, 7)); v.rdv  = ($urandom_range(0, 3) != 0);
      v.sys  = ($urandom_range(0, 4) == 0);
      v.wbv  = ($urandom_range(0, 2) != 0);
      v.wbrd = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 8) begin
        for (int k = 0; k < 8; k++) begin
          int r;
          r = $urandom_range(1, 7);
          if (busy[r]) begin
            v.wbrd = 5'(r);
            break;
          end
        end
      end
      v.fl = ($urandom_range(0, 39) == 0);
      v.exp_stall = 0; v.exp_issue = 0; v.exp_pend = 0; v.exp_cnt = 0;
      model(v);
      apply(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
